// File: rtl/booth_ctrl.sv
// Sequencing controller for a 16-bit radix-2 Booth multiplier datapath.
// Loads M/Q/B over the shared data bus, steps the add/shift loop, returns {A,Q}.
module booth_ctrl #(
    parameter int WIDTH    = 16,
    parameter int CNT_INIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    input  logic                 q0,
    input  logic                 qm1,
    input  logic                 eqz,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     Q,
    output logic [WIDTH-1:0]     data_bus,
    output logic                 ldA,
    output logic                 clrA,
    output logic                 ldQ,
    output logic                 clrQ,
    output logic                 ldM,
    output logic                 clrFF,
    output logic                 shift,
    output logic                 addsub,
    output logic                 ldB,
    output logic                 count,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ovf_warn
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_M = 3'd1;
    localparam logic [2:0] S_LOAD_Q = 3'd2;
    localparam logic [2:0] S_LOAD_B = 3'd3;
    localparam logic [2:0] S_EVAL   = 3'd4;
    localparam logic [2:0] S_SHIFT  = 3'd5;
    localparam logic [2:0] S_CHECK  = 3'd6;
    localparam logic [2:0] S_RESULT = 3'd7;

    localparam logic [WIDTH-1:0] LP_CNT     = WIDTH'(CNT_INIT);
    localparam logic [WIDTH-1:0] LP_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2:0]         r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_ovf;
    logic [2*WIDTH-1:0] r_product;
    logic               r_ovf_warn;
    logic               w_accept;

    assign in_ready  = rst_n && (r_state == S_IDLE);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_RESULT);
    assign product   = r_product;
    assign ovf_warn  = r_ovf_warn;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_ovf      <= 1'b0;
            r_product  <= '0;
            r_ovf_warn <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= mcand;
                        r_mplier <= mplier;
                        r_ovf    <= (mcand == LP_MOST_NEG);
                        r_state  <= S_LOAD_M;
                    end
                end
                S_LOAD_M: r_state <= S_LOAD_Q;
                S_LOAD_Q: r_state <= S_LOAD_B;
                S_LOAD_B: r_state <= S_EVAL;
                S_EVAL:   r_state <= S_SHIFT;
                S_SHIFT:  r_state <= S_CHECK;
                // eqz here already reflects the decrement issued in SHIFT.
                S_CHECK: begin
                    if (eqz) begin
                        r_state <= S_EVAL;
                    end else begin
                        r_product  <= {A, Q};
                        r_ovf_warn <= r_ovf;
                        r_state    <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first so no latch is inferred for the unlisted states.
    always_comb begin
        data_bus = '0;
        ldA      = 1'b0;
        clrA     = 1'b0;
        ldQ      = 1'b0;
        clrQ     = 1'b0;
        ldM      = 1'b0;
        clrFF    = 1'b0;
        shift    = 1'b0;
        addsub   = 1'b0;
        ldB      = 1'b0;
        count    = 1'b0;
        case (r_state)
            S_LOAD_M: begin
                data_bus = r_mcand;
                ldM      = 1'b1;
                clrA     = 1'b1;
                clrFF    = 1'b1;
            end
            S_LOAD_Q: begin
                data_bus = r_mplier;
                ldQ      = 1'b1;
            end
            S_LOAD_B: begin
                data_bus = LP_CNT;
                ldB      = 1'b1;
            end
            S_EVAL: begin
                // 01 adds M, 10 subtracts M; 00/11 leave A alone with addsub parked high.
                ldA    = q0 ^ qm1;
                addsub = ~(q0 & ~qm1);
            end
            S_SHIFT: begin
                shift = 1'b1;
                count = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: behavioural 16-bit datapath around the controller, products
// compared against plain signed multiplication, plus strobe, handshake and reset scenarios.
module tb_booth_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic        q0;
    logic        qm1;
    logic        eqz;
    logic [15:0] A;
    logic [15:0] Q;
    logic [15:0] data_bus;
    logic        ldA, clrA, ldQ, clrQ, ldM, clrFF, shift, addsub, ldB, count;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        ovf_warn;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    booth_ctrl #(.WIDTH(16), .CNT_INIT(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mcand(mcand), .mplier(mplier), .q0(q0), .qm1(qm1), .eqz(eqz),
        .A(A), .Q(Q), .data_bus(data_bus), .ldA(ldA), .clrA(clrA), .ldQ(ldQ),
        .clrQ(clrQ), .ldM(ldM), .clrFF(clrFF), .shift(shift), .addsub(addsub),
        .ldB(ldB), .count(count), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .ovf_warn(ovf_warn)
    );

    // Behavioural datapath: A, Q, Q[-1], M, counter B.
    logic [15:0] dp_a = '0, dp_q = '0, dp_m = '0, dp_b = '0;
    logic        dp_qm1 = 1'b0;

    always @(posedge clk) begin
        if (clrA)       dp_a <= '0;
        else if (ldA)   dp_a <= addsub ? dp_a + dp_m : dp_a - dp_m;
        else if (shift) dp_a <= {dp_a[15], dp_a[15:1]};
        if (ldQ)        dp_q <= data_bus;
        else if (shift) dp_q <= {dp_a[0], dp_q[15:1]};
        if (ldM)        dp_m <= data_bus;
        if (clrFF)      dp_qm1 <= 1'b0;
        else if (shift) dp_qm1 <= dp_q[0];
        if (ldB)        dp_b <= data_bus;
        else if (count) dp_b <= dp_b - 16'd1;
    end

    assign q0  = dp_q[0];
    assign qm1 = dp_qm1;
    assign eqz = (dp_b != 16'd0);
    assign A   = dp_a;
    assign Q   = dp_q;

    // {ldA,clrA,ldQ,clrQ,ldM,clrFF,shift,addsub,ldB,count}
    logic [9:0] strb;
    assign strb = {ldA, clrA, ldQ, clrQ, ldM, clrFF, shift, addsub, ldB, count};

    logic [9:0]  tr_strb [0:127];
    logic [15:0] tr_bus  [0:127];

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return 32'(sa * sb);
    endfunction

    task automatic run_op(input logic [15:0] mc, input logic [15:0] mp, input int hold,
                          output logic [31:0] prod, output logic got_ovf,
                          output int lat, output int shifts);
        int g, cyc, busy_bad, lda_bad, hold_bad;
        logic [31:0] p0;
        g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        in_valid  = 1'b1;
        mcand     = mc;
        mplier    = mp;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        mcand    = 16'($urandom);
        mplier   = 16'($urandom);
        cyc = 1; shifts = 0; busy_bad = 0; lda_bad = 0;
        while (!out_valid && cyc < 120) begin
            tr_strb[cyc] = strb;
            tr_bus[cyc]  = data_bus;
            if (shift) shifts++;
            if (in_ready) busy_bad++;
            if (clrQ) lda_bad++;
            if (ldA && !((q0 ^ qm1) && (addsub == qm1))) lda_bad++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        lat     = cyc;
        prod    = product;
        got_ovf = ovf_warn;
        n_checks++;
        if (busy_bad != 0 || lda_bad != 0) begin
            n_fail++;
            $display("FAIL busy_strobes: in_ready-while-busy=%0d bad-ldA/clrQ=%0d, required 0/0", busy_bad, lda_bad);
        end
        if (!out_valid) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: out_valid not seen within %0d cycles", cyc);
        end
        hold_bad = 0;
        p0 = product;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            mcand    = 16'($urandom);
            mplier   = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (product !== p0 || in_ready !== 1'b0 || out_valid !== 1'b1) hold_bad++;
        end
        if (hold > 0) begin
            n_checks++;
            if (hold_bad != 0) begin
                n_fail++;
                $display("FAIL backpressure_hold: %0d bad cycles (product %h vs %h), required 0", hold_bad, product, p0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic check_op(input string name, input logic [15:0] mc, input logic [15:0] mp, input int hold);
        logic [31:0] prod, exp;
        logic        ov;
        int          lat, sh;
        exp = ref_mul(mc, mp);
        run_op(mc, mp, hold, prod, ov, lat, sh);
        n_checks += 4;
        if (prod !== exp) begin
            n_fail++;
            $display("FAIL %s product: %h*%h got %h, required %h", name, mc, mp, prod, exp);
        end
        if (ov !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ovf_warn: got %b, required 0", name, ov);
        end
        if (lat != 52) begin
            n_fail++;
            $display("FAIL %s latency: got %0d, required 52", name, lat);
        end
        if (sh != 16) begin
            n_fail++;
            $display("FAIL %s shift_pulses: got %0d, required 16", name, sh);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mcand = '0; mplier = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 0", in_ready);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (strb !== 10'd0 || data_bus !== 16'd0 || out_valid !== 1'b0 || product !== 32'd0
            || ovf_warn !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: strb=%b bus=%h ov=%b prod=%h warn=%b rdy=%b, required 0/0/0/0/0/1",
                     strb, data_bus, out_valid, product, ovf_warn, in_ready);
        end
    endtask

    task automatic test_known_values();
        check_op("3x5", 16'd3, 16'd5, 0);
        check_op("m7x6", 16'hFFF9, 16'd6, 0);
        check_op("m32767xm32768", 16'h8001, 16'h8000, 0);
        check_op("max_pos_sq", 16'h7FFF, 16'h7FFF, 0);
        check_op("zero", 16'd0, 16'h1234, 0);
    endtask

    task automatic test_strobe_trace();
        logic [31:0] prod;
        logic        ov;
        int          lat, sh;
        logic [9:0]  exp_s [0:5];
        int          idx   [0:5];
        exp_s[0] = 10'b0100110000; idx[0] = 1;   // LOAD_M: clrA ldM clrFF
        exp_s[1] = 10'b0010000000; idx[1] = 2;   // LOAD_Q: ldQ
        exp_s[2] = 10'b0000000010; idx[2] = 3;   // LOAD_B: ldB
        exp_s[3] = 10'b0000000100; idx[3] = 4;   // EVAL 00
        exp_s[4] = 10'b1000000000; idx[4] = 7;   // EVAL 10: subtract
        exp_s[5] = 10'b1000000100; idx[5] = 10;  // EVAL 01: add
        run_op(16'h0123, 16'h0002, 0, prod, ov, lat, sh);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (tr_strb[idx[i]] !== exp_s[i]) begin
                n_fail++;
                $display("FAIL trace_cycle%0d: strobes %b, required %b", idx[i], tr_strb[idx[i]], exp_s[i]);
            end
        end
        n_checks += 3;
        if (tr_bus[1] !== 16'h0123 || tr_bus[2] !== 16'h0002 || tr_bus[3] !== 16'd16) begin
            n_fail++;
            $display("FAIL trace_bus: %h %h %h, required 0123 0002 0010", tr_bus[1], tr_bus[2], tr_bus[3]);
        end
        if (tr_strb[5] !== 10'b0000001001) begin
            n_fail++;
            $display("FAIL trace_shift: strobes %b, required 0000001001", tr_strb[5]);
        end
        if (sh != 16 || prod !== 32'h0000_0246) begin
            n_fail++;
            $display("FAIL trace_result: shifts=%0d prod=%h, required 16 00000246", sh, prod);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (a == 16'h8000) a = 16'h8001;
            check_op("random", a, b, 0);
        end
    endtask

    task automatic test_backpressure();
        check_op("bp_hold10", 16'd1000, 16'hFF38, 10);
        check_op("bp_next", 16'd77, 16'd91, 0);
    endtask

    task automatic test_back_to_back();
        check_op("b2b_a", 16'h7FFF, 16'h8000, 0);
        check_op("b2b_b", 16'hFFFF, 16'hFFFF, 0);
    endtask

    task automatic test_mid_op_reset();
        int cyc;
        in_valid = 1'b1; mcand = 16'd123; mplier = 16'd456; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (cyc < 26) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (shift !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_8th_shift: shift=%b at cycle 26, required 1", shift);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_in_ready: got %b, required 0", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (strb !== 10'd0 || data_bus !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_idle: strb=%b bus=%h ov=%b rdy=%b, required 0/0/0/1", strb, data_bus, out_valid, in_ready);
        end
        @(negedge clk);
        check_op("after_reset_2x2", 16'd2, 16'd2, 0);
    endtask

    task automatic test_overflow();
        logic [31:0] prod;
        logic        ov;
        int          lat, sh;
        run_op(16'h8000, 16'd1, 0, prod, ov, lat, sh);
        n_checks += 2;
        if (ov !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_warn: got %b, required 1", ov);
        end
        if (lat != 52) begin
            n_fail++;
            $display("FAIL ovf_latency: got %0d, required 52", lat);
        end
        check_op("ovf_cleared", 16'd9, 16'h8000, 0);
    endtask

    initial begin
        test_reset();
        test_known_values();
        test_strobe_trace();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_mid_op_reset();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_ctrl.md
Name: booth_ctrl

Overview:
- Sequencing controller that sits directly upstream of the 16-bit Booth multiplier datapath and drives all of its control strobes and its shared 16-bit data_in bus.
- Accepts a multiplicand/multiplier pair on a valid/ready input handshake.
- Loads the pair into the datapath registers, then runs the Booth iteration loop using the datapath status bits q0, qm1 and eqz.
- Captures the 32-bit signed product {A,Q} and presents it on a valid/ready output handshake.

Parameters:
WIDTH, 16, operand width; must equal the datapath width (only 16 is supported)
CNT_INIT, 16, iteration count loaded into datapath counter B (equals WIDTH)

Ports:
clk  input  1  rising-edge clock, shared with the datapath
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands
mcand  input  16  signed multiplicand, captured on accept
mplier  input  16  signed multiplier, captured on accept
q0  input  1  datapath Q[0]
qm1  input  1  datapath Q[-1] flip-flop
eqz  input  1  datapath counter status; HIGH while counter B is non-zero
A  input  16  datapath accumulator
Q  input  16  datapath multiplier register
data_bus  output  16  drives datapath data_in
ldA, clrA, ldQ, clrQ, ldM, clrFF, shift, addsub, ldB, count  output  1 each  datapath strobes; addsub=1 adds, addsub=0 subtracts
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  32  signed product {A,Q}
ovf_warn  output  1  product unreliable (multiplicand was 0x8000); valid with out_valid

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; all strobes 0; data_bus=0; out_valid=0; product=0; ovf_warn=0; internal operand latches 0.
  - in_ready=0 while rst_n=0.
  - Reset mid-operation abandons the operation; no output is produced.
- Strobe encoding: every strobe is a registered-free Moore decode of state, except addsub and ldA in EVAL, which also depend on q0/qm1. Each strobe is high for exactly the cycles listed below; 0 otherwise.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready: latch mcand and mplier; latch ovf flag = (mcand==16'h8000); go to LOAD_M.
  - LOAD_M: data_bus=mcand latch; ldM=1, clrA=1, clrFF=1; go to LOAD_Q.
  - LOAD_Q: data_bus=mplier latch; ldQ=1; go to LOAD_B.
  - LOAD_B: data_bus=CNT_INIT; ldB=1; go to EVAL.
  - EVAL, decoded from {q0,qm1}:
    - 01: ldA=1, addsub=1 (A+M).
    - 10: ldA=1, addsub=0 (A-M).
    - 00 or 11: no strobe; addsub=1 (don't-care, held at 1).
    - Go to SHIFT.
  - SHIFT: shift=1, count=1 (arithmetic right shift of A:Q:qm1; B decrements); go to CHECK.
  - CHECK:
    - Samples the post-decrement eqz.
    - eqz=1: go to EVAL.
    - eqz=0: register product<={A,Q} and ovf_warn<=ovf flag; go to RESULT.
  - RESULT:
    - out_valid=1; product and ovf_warn held stable.
    - On out_ready: out_valid falls next cycle; go to IDLE.
- in_ready is 0 in every state except IDLE. No operand is accepted in the same cycle as the RESULT handshake; the earliest accept is the cycle after.
- Latency: accept edge at cycle 0 → out_valid high at cycle 3+3*CNT_INIT+1 = 52.
- Throughput: one product per 53 cycles minimum, with out_ready held high.
- Datapath timing: the datapath samples strobes at the same edge the controller transitions on. q0/qm1/eqz are registered datapath outputs and are valid in the cycle after the strobe that changed them, which is why CHECK follows SHIFT.
- Arithmetic: result is 32-bit two's complement.
  - mcand=0x8000 can overflow the 16-bit accumulator on subtraction.
  - The controller still completes the sequence, but ovf_warn=1 and the product is not guaranteed.
  - All other operand pairs, including mplier=0x8000, yield the exact product.
- out_ready held high while out_valid=0 has no effect.
- in_valid while busy is ignored; the operands must be held by the source until accepted.

Test Plan:
- Reset then mcand=3, mplier=5, out_ready=1 → out_valid at cycle 52 after accept; product=32'd15; ovf_warn=0.
- mcand=-7 (0xFFF9), mplier=6 → product=32'hFFFF_FFD6 (-42); mcand=-32767, mplier=-32768 → product=32'h3FFF_8000.
- Strobe trace, mplier=0x0002: EVAL #1 ({q0,qm1}=00) has no ldA; EVAL #2 (10) has ldA=1, addsub=0; EVAL #3 (01) has ldA=1, addsub=1; exactly 16 shift pulses per operation.
- Output backpressure: out_ready=0 for 10 cycles after out_valid → product stable, in_ready=0, in_valid ignored; out_ready=1 → IDLE next cycle, then a new operand pair is accepted.
- rst_n=0 for one cycle during the 8th SHIFT → next cycle IDLE, all strobes 0, out_valid=0; a fresh 2×2 operation yields product=4.
- mcand=0x8000, mplier=1 → out_valid asserts at cycle 52 with ovf_warn=1.
